fix_tx_framer: RTL
==================

# fix_tx_framer

Transmit-side framing stage directly downstream of the FIX header encoder. Accepts one fully encoded FIX message (header plus body, every field SOH-terminated, no trailer) as a flat byte vector with a length, streams it out one byte per cycle over a valid/ready interface, and computes the FIX CheckSum on the fly. It appends the standard trailer `10=NNN<SOH>`. Its output feeds the TCP/MAC transmit byte path.

## Interface
- MAX_MSG_BYTES, 256: largest accepted message in bytes, trailer excluded.
- LEN_W, $clog2(MAX_MSG_BYTES+1): width of msg_len.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- msg_data  in  MAX_MSG_BYTES*8  encoded message; byte i at bits [8i+7:8i], byte 0 sent first.
- msg_len  in  LEN_W  number of valid bytes in msg_data.
- msg_valid  in  1  message offered.
- msg_ready  out  1  framer can accept a message.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts byte.
- tx_last  out  1  marks final trailer byte (SOH).
- frame_done  out  1  one-cycle pulse, frame fully sent.
- err_len  out  1  one-cycle pulse, message rejected for bad length.
- busy  out  1  high while not in IDLE.

## Operation
- FSM states: IDLE, BODY, TRAILER.
- IDLE:
  - msg_ready=1.
  - On msg_valid&&msg_ready with 1 ≤ msg_len ≤ MAX_MSG_BYTES: register msg_data and msg_len, clear the byte index and checksum, go to BODY.
  - If msg_len==0 or msg_len>MAX_MSG_BYTES: the message is consumed and dropped, err_len pulses, state stays IDLE.
- BODY:
  - tx_valid=1 and tx_data = captured byte[idx].
  - On each tx handshake: checksum ← (checksum + byte) mod 256, idx+1.
  - The handshake of byte msg_len-1 moves the FSM to TRAILER with trailer index 0.
- TRAILER:
  - Emits 7 bytes in order: 0x31 '1', 0x30 '0', 0x3D '=', hundreds, tens, ones, 0x01.
  - Each digit byte is 0x30 + digit of the 8-bit checksum, zero-padded to 3 digits.
  - Decimal split is done by compare/subtract on 0..255; no divider.
  - tx_last=1 only on the SOH byte.
  - The SOH handshake returns the FSM to IDLE.
- Checksum is the 8-bit modulo-256 sum of all msg_len bytes. Trailer bytes are excluded.
- Output frame length is always msg_len+7 bytes.
- The captured message is held internally, so msg_data may change after acceptance.

## Timing
- Reset values:
  - msg_ready=0 during reset, then 1 in the first cycle in IDLE.
  - tx_valid=0, tx_data=0x00, tx_last=0, frame_done=0, err_len=0, busy=0.
  - Internal checksum and indexes reset to 0.
- Latency: tx_valid rises in the cycle after the accept handshake, carrying byte 0.
- Throughput: one byte per cycle while tx_ready=1; no bubble at the BODY→TRAILER boundary.
- Backpressure: while tx_valid=1 and tx_ready=0, tx_data and tx_last hold stable. tx_valid never drops before its handshake.
- frame_done pulses in the cycle after the tx_last handshake. msg_ready is also 1 in that cycle, so back-to-back frames have a one-cycle gap on tx_valid.
- err_len pulses in the cycle after the rejected handshake. msg_ready stays 1.
- msg_ready=0 in BODY and TRAILER; msg_valid is ignored there.
- Reset mid-frame: all outputs return to reset values on the next edge. The partial frame is abandoned with no trailer and no frame_done.
- The checksum register is 8 bits and wraps naturally; no saturation.

## Test plan
- Basic frame: bytes 0x41,0x42,0x01 with len 3, tx_ready=1.
  - Required: tx stream 41 42 01 31 30 3D 31 33 32 01 ("10=132").
  - tx_last on the final byte; frame_done the cycle after.
- Wrap and zero-pad: bytes FF FF 02 01 with len 4.
  - Required: checksum 0x01, trailer 31 30 3D 30 30 31 01 ("10=001").
- Backpressure: basic frame with tx_ready toggling 1,0,0,1 pseudo-randomly.
  - Required: identical byte sequence; tx_data stable during every stall; msg_ready=0 throughout.
- Length errors: msg_len=0, then msg_len=MAX_MSG_BYTES+1.
  - Required: err_len pulses once each; no tx_valid; next valid message framed normally.
- Max length plus back-to-back: 256 bytes of 0x01, then an immediately offered second message.
  - Required: first frame ends in trailer "10=000"; second accepted in the frame_done cycle; a one-cycle tx_valid gap between frames.
- Reset mid-frame: assert rst_n=0 after byte 5 of a 20-byte message.
  - Required: tx_valid=0 next cycle, no frame_done, clean framing of the next message.

Source files
------------

// File: rtl/fix_tx_framer.sv
// rtl/fix_tx_framer.sv - streams one encoded FIX message byte-wise and appends the "10=NNN<SOH>" trailer
module fix_tx_framer #(
    parameter int MAX_MSG_BYTES = 256,
    parameter int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [MAX_MSG_BYTES*8-1:0] msg_data,
    input  logic [LEN_W-1:0]           msg_len,
    input  logic                       msg_valid,
    output logic                       msg_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       tx_last,
    output logic                       frame_done,
    output logic                       err_len,
    output logic                       busy
);

    localparam int IDX_W = (MAX_MSG_BYTES > 1) ? $clog2(MAX_MSG_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, BODY, TRAILER} state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       mem [MAX_MSG_BYTES];
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx;
    logic [2:0]       tidx;
    logic [7:0]       csum;

    logic             accept;
    logic             len_ok;
    logic             tx_hs;
    logic             body_end;
    logic             trailer_end;
    logic [3:0]       hund;
    logic [3:0]       tens;
    logic [7:0]       rem;
    logic [7:0]       ones;
    logic [7:0]       trl_byte;

    assign accept      = msg_valid && msg_ready;
    assign len_ok      = (msg_len != '0) && (msg_len <= LEN_W'(MAX_MSG_BYTES));
    assign tx_hs       = tx_valid && tx_ready;
    assign body_end    = (state == BODY) && tx_hs && (LEN_W'(idx) == len_q - LEN_W'(1));
    assign trailer_end = (state == TRAILER) && tx_hs && (tidx == 3'd6);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && len_ok) state_next = BODY;
            BODY:    if (body_end)         state_next = TRAILER;
            TRAILER: if (trailer_end)      state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Decimal split of the checksum by compare/subtract; the last matching tens step wins.
    always_comb begin
        hund = 4'd0;
        rem  = csum;
        if (csum >= 8'd200) begin
            hund = 4'd2;
            rem  = csum - 8'd200;
        end else if (csum >= 8'd100) begin
            hund = 4'd1;
            rem  = csum - 8'd100;
        end
        tens = 4'd0;
        ones = rem;
        for (int k = 1; k <= 9; k++) begin
            if (rem >= 8'(10 * k)) begin
                tens = 4'(k);
                ones = rem - 8'(10 * k);
            end
        end
    end

    always_comb begin
        case (tidx)
            3'd0:    trl_byte = 8'h31;
            3'd1:    trl_byte = 8'h30;
            3'd2:    trl_byte = 8'h3D;
            3'd3:    trl_byte = 8'h30 | {4'h0, hund};
            3'd4:    trl_byte = 8'h30 | {4'h0, tens};
            3'd5:    trl_byte = 8'h30 | {4'h0, ones[3:0]};
            default: trl_byte = 8'h01;
        endcase
    end

    always_comb begin
        msg_ready = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_last   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    msg_ready = rst_n;
            BODY: begin
                tx_valid = 1'b1;
                tx_data  = mem[idx];
            end
            TRAILER: begin
                tx_valid = 1'b1;
                tx_data  = trl_byte;
                tx_last  = (tidx == 3'd6);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q      <= '0;
            idx        <= '0;
            tidx       <= '0;
            csum       <= '0;
            frame_done <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            frame_done <= trailer_end;
            err_len    <= accept && !len_ok;
            if (accept && len_ok) begin
                len_q <= msg_len;
                idx   <= '0;
                tidx  <= '0;
                csum  <= '0;
            end
            if (state == BODY && tx_hs) begin
                csum <= csum + tx_data;
                idx  <= idx + 1'b1;
            end
            if (state == TRAILER && tx_hs) begin
                tidx <= tidx + 3'd1;
            end
        end
    end

    // Message storage carries no reset: it is always rewritten on accept before use.
    always_ff @(posedge clk) begin
        if (accept && len_ok) begin
            for (int i = 0; i < MAX_MSG_BYTES; i++) begin
                mem[i] <= msg_data[8*i +: 8];
            end
        end
    end

endmodule
